// File: rtl/regfile_2w4r_pkg.sv
// Shared core definitions for the dual-issue integer register file and its
// write-back producer: data width, register address width and the writeback bundle.
package regfile_2w4r_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

  typedef struct packed {
    logic [XLEN-1:0] data;
    reg_addr_t       dstreg;
    logic            en;
  } wb_bundle_t;

endpackage

// File: rtl/regfile_2w4r_if.sv
// Bus between the write-back/decode stages (master) and the register file (slave):
// two writeback lanes in, four source addresses in, four read data and conflict flag out.
interface regfile_2w4r_if #(
  parameter int XLEN = regfile_2w4r_pkg::XLEN
);
  import regfile_2w4r_pkg::*;

  logic [XLEN-1:0] wb_dataRW1;
  reg_addr_t       dstregRW1;
  logic            wb_enRW1;
  logic [XLEN-1:0] wb_dataRW2;
  reg_addr_t       dstregRW2;
  logic            wb_enRW2;

  reg_addr_t       rs1_addr1;
  reg_addr_t       rs2_addr1;
  reg_addr_t       rs1_addr2;
  reg_addr_t       rs2_addr2;

  logic [XLEN-1:0] rs1_data1;
  logic [XLEN-1:0] rs2_data1;
  logic [XLEN-1:0] rs1_data2;
  logic [XLEN-1:0] rs2_data2;
  logic            wr_conflict;

  modport master (
    output wb_dataRW1, dstregRW1, wb_enRW1,
    output wb_dataRW2, dstregRW2, wb_enRW2,
    output rs1_addr1, rs2_addr1, rs1_addr2, rs2_addr2,
    input  rs1_data1, rs2_data1, rs1_data2, rs2_data2, wr_conflict
  );

  modport slave (
    input  wb_dataRW1, dstregRW1, wb_enRW1,
    input  wb_dataRW2, dstregRW2, wb_enRW2,
    input  rs1_addr1, rs2_addr1, rs1_addr2, rs2_addr2,
    output rs1_data1, rs2_data1, rs1_data2, rs2_data2, wr_conflict
  );

endinterface

// File: rtl/regfile_2w4r_rdport.sv
// One combinational read port: storage lookup, optional two-lane write-through
// bypass (younger lane first), then x0 and out-of-range forcing to zero.
module regfile_2w4r_rdport
  import regfile_2w4r_pkg::*;
#(
  parameter int XLEN   = regfile_2w4r_pkg::XLEN,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  reg_addr_t       addr,
  input  logic [XLEN-1:0] regs [1 << REG_ADDR_W],
  input  logic [XLEN-1:0] wb_data1,
  input  reg_addr_t       dstreg1,
  input  logic            wb_en1,
  input  logic [XLEN-1:0] wb_data2,
  input  reg_addr_t       dstreg2,
  input  logic            wb_en2,
  output logic [XLEN-1:0] rd_data
);

  always_comb begin
    rd_data = regs[addr];
    if (BYPASS) begin
      if (wb_en2 && (addr == dstreg2)) begin
        rd_data = wb_data2;
      end else if (wb_en1 && (addr == dstreg1)) begin
        rd_data = wb_data1;
      end
    end
    // Applied last so a bypassed write to x0 or a missing register never leaks through.
    if ((addr == ZERO_REG) || (int'(addr) >= NREGS)) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/regfile_2w4r.sv
// Architectural register file: two writeback lanes (lane 2 younger, wins on
// collision), four bypassed read ports, x0 hardwired to zero.
module regfile_2w4r
  import regfile_2w4r_pkg::*;
#(
  parameter int XLEN   = regfile_2w4r_pkg::XLEN,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  regfile_2w4r_if.slave bus
);

  localparam int DEPTH = 1 << REG_ADDR_W;

  logic [XLEN-1:0] regs_reg [DEPTH];
  logic            wr_conflict_reg;
  logic            wr1_ok;
  logic            wr2_ok;
  logic            byp_en1;
  logic            byp_en2;
  reg_addr_t       rd_addr [4];
  logic [XLEN-1:0] rd_data [4];

  // Writes to x0 or beyond NREGS are dropped here, so those entries stay zero forever.
  assign wr1_ok = bus.wb_enRW1 && (bus.dstregRW1 != ZERO_REG) && (int'(bus.dstregRW1) < NREGS);
  assign wr2_ok = bus.wb_enRW2 && (bus.dstregRW2 != ZERO_REG) && (int'(bus.dstregRW2) < NREGS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
      wr_conflict_reg <= 1'b0;
    end else begin
      if (wr1_ok) begin
        regs_reg[bus.dstregRW1] <= bus.wb_dataRW1;
      end
      // Lane 2 is assigned after lane 1 so it takes the register on a collision.
      if (wr2_ok) begin
        regs_reg[bus.dstregRW2] <= bus.wb_dataRW2;
      end
      wr_conflict_reg <= wr1_ok && wr2_ok && (bus.dstregRW1 == bus.dstregRW2);
    end
  end

  // Bypass is muted during reset so every read port shows zero while rst_n is low.
  assign byp_en1 = bus.wb_enRW1 && rst_n;
  assign byp_en2 = bus.wb_enRW2 && rst_n;

  assign rd_addr[0] = bus.rs1_addr1;
  assign rd_addr[1] = bus.rs2_addr1;
  assign rd_addr[2] = bus.rs1_addr2;
  assign rd_addr[3] = bus.rs2_addr2;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rdport
      regfile_2w4r_rdport #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
      ) u_rdport (
        .addr     (rd_addr[gi]),
        .regs     (regs_reg),
        .wb_data1 (bus.wb_dataRW1),
        .dstreg1  (bus.dstregRW1),
        .wb_en1   (byp_en1),
        .wb_data2 (bus.wb_dataRW2),
        .dstreg2  (bus.dstregRW2),
        .wb_en2   (byp_en2),
        .rd_data  (rd_data[gi])
      );
    end
  endgenerate

  assign bus.rs1_data1   = rd_data[0];
  assign bus.rs2_data1   = rd_data[1];
  assign bus.rs1_data2   = rd_data[2];
  assign bus.rs2_data2   = rd_data[3];
  assign bus.wr_conflict = wr_conflict_reg;

  assert property (@(posedge clk) disable iff (!rst_n)
                   !$isunknown({bus.wb_enRW1, bus.wb_enRW2}));

endmodule

// File: tb/tb_regfile_2w4r.sv
// Drives two register files (bypassing 32-entry, non-bypassing 16-entry) with the
// same stimulus and checks them against an array model plus literal expectations.
module tb_regfile_2w4r;
  import regfile_2w4r_pkg::*;

  logic       clk;
  logic       rst_n;
  wb_bundle_t l1;
  wb_bundle_t l2;
  reg_addr_t  ra [4];

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  logic        conf_a;
  logic        conf_b;

  regfile_2w4r_if #(.XLEN(32)) ifa ();
  regfile_2w4r_if #(.XLEN(32)) ifb ();

  regfile_2w4r #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) ua (.clk(clk), .rst_n(rst_n), .bus(ifa));
  regfile_2w4r #(.XLEN(32), .NREGS(16), .BYPASS(1'b0)) ub (.clk(clk), .rst_n(rst_n), .bus(ifb));

  assign ifa.wb_dataRW1 = l1.data;
  assign ifa.dstregRW1  = l1.dstreg;
  assign ifa.wb_enRW1   = l1.en;
  assign ifa.wb_dataRW2 = l2.data;
  assign ifa.dstregRW2  = l2.dstreg;
  assign ifa.wb_enRW2   = l2.en;
  assign ifa.rs1_addr1  = ra[0];
  assign ifa.rs2_addr1  = ra[1];
  assign ifa.rs1_addr2  = ra[2];
  assign ifa.rs2_addr2  = ra[3];
  assign ifb.wb_dataRW1 = l1.data;
  assign ifb.dstregRW1  = l1.dstreg;
  assign ifb.wb_enRW1   = l1.en;
  assign ifb.wb_dataRW2 = l2.data;
  assign ifb.dstregRW2  = l2.dstreg;
  assign ifb.wb_enRW2   = l2.en;
  assign ifb.rs1_addr1  = ra[0];
  assign ifb.rs2_addr1  = ra[1];
  assign ifb.rs1_addr2  = ra[2];
  assign ifb.rs2_addr2  = ra[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] rd_a(input int k);
    case (k)
      0:       return ifa.rs1_data1;
      1:       return ifa.rs2_data1;
      2:       return ifa.rs1_data2;
      default: return ifa.rs2_data2;
    endcase
  endfunction

  function automatic logic [31:0] rd_b(input int k);
    case (k)
      0:       return ifb.rs1_data1;
      1:       return ifb.rs2_data1;
      2:       return ifb.rs1_data2;
      default: return ifb.rs2_data2;
    endcase
  endfunction

  // Expected read: zero in reset / x0 / missing register, else youngest bypass, else stored.
  function automatic logic [31:0] exp_rd(input bit inst_b, input reg_addr_t a);
    int nregs;
    nregs = inst_b ? 16 : 32;
    if (!rst_n || (a == 5'd0) || (int'(a) >= nregs)) return 32'h0;
    if (!inst_b && l2.en && (l2.dstreg == a)) return l2.data;
    if (!inst_b && l1.en && (l1.dstreg == a)) return l1.data;
    return inst_b ? mem_b[a] : mem_a[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem_a[i] <= 32'h0;
        mem_b[i] <= 32'h0;
      end
      conf_a <= 1'b0;
      conf_b <= 1'b0;
    end else begin
      if (l1.en && (l1.dstreg != 5'd0)) mem_a[l1.dstreg] <= l1.data;
      if (l2.en && (l2.dstreg != 5'd0)) mem_a[l2.dstreg] <= l2.data;
      if (l1.en && (l1.dstreg != 5'd0) && (l1.dstreg < 5'd16)) mem_b[l1.dstreg] <= l1.data;
      if (l2.en && (l2.dstreg != 5'd0) && (l2.dstreg < 5'd16)) mem_b[l2.dstreg] <= l2.data;
      conf_a <= l1.en && l2.en && (l1.dstreg == l2.dstreg) && (l1.dstreg != 5'd0);
      conf_b <= l1.en && l2.en && (l1.dstreg == l2.dstreg) && (l1.dstreg != 5'd0)
                && (l1.dstreg < 5'd16);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      check($sformatf("model_a_rd%0d", k), rd_a(k), exp_rd(1'b0, ra[k]));
      check($sformatf("model_b_rd%0d", k), rd_b(k), exp_rd(1'b1, ra[k]));
    end
    check("model_a_conflict", {31'b0, ifa.wr_conflict}, {31'b0, conf_a});
    check("model_b_conflict", {31'b0, ifb.wr_conflict}, {31'b0, conf_b});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    l1.en = 1'b0;
    l2.en = 1'b0;
  endtask

  task automatic set_rd(input reg_addr_t a0, input reg_addr_t a1, input reg_addr_t a2, input reg_addr_t a3);
    ra[0] = a0;
    ra[1] = a1;
    ra[2] = a2;
    ra[3] = a3;
  endtask

  initial begin
    rst_n = 1'b0;
    l1 = '0;
    l2 = '0;
    set_rd(5'd0, 5'd0, 5'd0, 5'd0);
    repeat (3) step();
    rst_n = 1'b1;

    // Reset state: every address on every port reads zero.
    for (int a = 0; a < 32; a++) begin
      set_rd(reg_addr_t'(a), reg_addr_t'(a), reg_addr_t'(a), reg_addr_t'(a));
      step();
      #2;
      check($sformatf("reset_a_x%0d", a), ifa.rs2_data2, 32'h0);
      check($sformatf("reset_b_x%0d", a), ifb.rs1_data1, 32'h0);
    end

    // Write x5, read it back, then async reset clears it without a clock edge.
    l1 = '{data: 32'h1234, dstreg: 5'd5, en: 1'b1};
    set_rd(5'd5, 5'd5, 5'd5, 5'd5);
    step();
    idle();
    #2;
    check("x5_stored_a", ifa.rs1_data1, 32'h1234);
    check("x5_stored_b", ifb.rs1_data1, 32'h1234);
    rst_n = 1'b0;
    #1;
    check("x5_async_reset_a", ifa.rs1_data1, 32'h0);
    check("x5_async_reset_b", ifb.rs1_data1, 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // Lane 1 single write, read on two different ports next cycle.
    l1 = '{data: 32'hDEADBEEF, dstreg: 5'd3, en: 1'b1};
    step();
    idle();
    set_rd(5'd3, 5'd0, 5'd0, 5'd3);
    #2;
    check("x3_rs1_data1", ifa.rs1_data1, 32'hDEADBEEF);
    check("x3_rs2_data2", ifa.rs2_data2, 32'hDEADBEEF);
    check("x3_conflict", {31'b0, ifa.wr_conflict}, 32'h0);

    // Both lanes to x7: lane 2 wins, conflict pulses exactly one cycle.
    step();
    l1 = '{data: 32'h11, dstreg: 5'd7, en: 1'b1};
    l2 = '{data: 32'h22, dstreg: 5'd7, en: 1'b1};
    set_rd(5'd7, 5'd7, 5'd7, 5'd7);
    #2;
    check("x7_bypass_a", ifa.rs1_data1, 32'h22);
    check("x7_nobypass_b", ifb.rs1_data1, 32'h0);
    step();
    idle();
    #2;
    check("x7_stored_a", ifa.rs1_data2, 32'h22);
    check("x7_stored_b", ifb.rs2_data1, 32'h22);
    check("x7_conflict_a", {31'b0, ifa.wr_conflict}, 32'h1);
    check("x7_conflict_b", {31'b0, ifb.wr_conflict}, 32'h1);
    step();
    #2;
    check("x7_conflict_clear", {31'b0, ifa.wr_conflict}, 32'h0);

    // Write to x0 is discarded and never bypassed.
    l2 = '{data: 32'hFFFFFFFF, dstreg: 5'd0, en: 1'b1};
    set_rd(5'd0, 5'd0, 5'd0, 5'd0);
    #1;
    check("x0_same_cycle", ifa.rs1_data1, 32'h0);
    step();
    idle();
    #2;
    check("x0_next_cycle", ifa.rs2_data2, 32'h0);
    check("x0_conflict", {31'b0, ifa.wr_conflict}, 32'h0);

    // Bypass versus stored-only on x9.
    l1 = '{data: 32'hA, dstreg: 5'd9, en: 1'b1};
    step();
    l1 = '{data: 32'hB, dstreg: 5'd9, en: 1'b1};
    set_rd(5'd0, 5'd9, 5'd0, 5'd0);
    #2;
    check("x9_bypass_a", ifa.rs2_data1, 32'hB);
    check("x9_stored_b", ifb.rs2_data1, 32'hA);
    step();
    idle();
    #2;
    check("x9_next_b", ifb.rs2_data1, 32'hB);

    // Two lanes to different registers, four ports read them.
    l1 = '{data: 32'h4, dstreg: 5'd4, en: 1'b1};
    l2 = '{data: 32'h5, dstreg: 5'd5, en: 1'b1};
    set_rd(5'd4, 5'd5, 5'd4, 5'd5);
    step();
    idle();
    #2;
    check("x4_rs1_data1", ifa.rs1_data1, 32'h4);
    check("x5_rs2_data1", ifa.rs2_data1, 32'h5);
    check("x4_rs1_data2", ifa.rs1_data2, 32'h4);
    check("x5_rs2_data2", ifa.rs2_data2, 32'h5);

    // x20 exists only in the 32-entry instance.
    l1 = '{data: 32'h77, dstreg: 5'd20, en: 1'b1};
    set_rd(5'd20, 5'd20, 5'd20, 5'd20);
    #1;
    check("x20_bypass_a", ifa.rs1_data1, 32'h77);
    check("x20_range_b", ifb.rs1_data1, 32'h0);
    step();
    idle();
    #2;
    check("x20_stored_a", ifa.rs1_data1, 32'h77);
    check("x20_range_next_b", ifb.rs1_data1, 32'h0);

    // Reset held across a write edge: storage stays zero.
    l1 = '{data: 32'h55, dstreg: 5'd12, en: 1'b1};
    set_rd(5'd12, 5'd12, 5'd12, 5'd12);
    #1;
    rst_n = 1'b0;
    step();
    idle();
    rst_n = 1'b1;
    #2;
    check("x12_reset_wins_a", ifa.rs1_data1, 32'h0);
    check("x12_reset_wins_b", ifb.rs1_data1, 32'h0);

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 1500; n++) begin
      step();
      if (!rst_n) rst_n = 1'b1;
      l1.en     = ($urandom_range(0, 3) != 0);
      l1.dstreg = reg_addr_t'($urandom_range(0, 31));
      l1.data   = $urandom;
      l2.en     = ($urandom_range(0, 3) != 0);
      l2.dstreg = ($urandom_range(0, 3) == 0) ? l1.dstreg : reg_addr_t'($urandom_range(0, 31));
      l2.data   = $urandom;
      for (int k = 0; k < 4; k++) begin
        ra[k] = ($urandom_range(0, 3) == 0) ? l2.dstreg : reg_addr_t'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 199) == 0) begin
        #1;
        rst_n = 1'b0;
      end
    end
    step();
    rst_n = 1'b1;
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
